// File: rtl/icache_ctrl_if.sv
// Fetch-side and main-memory-side signal bundle of the instruction cache.
interface icache_ctrl_if;
  logic [15:0] addr;
  logic        rd;
  logic        abort;
  logic [15:0] instr;
  logic        valid;
  logic        ready;
  logic        err;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_err;

  modport slave (
    input  addr, rd, abort,
    input  mem_rdata, mem_rvalid, mem_err,
    output instr, valid, ready, err,
    output mem_rd, mem_addr
  );

  modport master (
    output addr, rd, abort,
    output mem_rdata, mem_rvalid, mem_err,
    input  instr, valid, ready, err,
    input  mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only icache, 4-word lines filled one word per beat.
// Define ICACHE_STATS_EN to build saturating hit/miss counters.
module icache_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  icache_ctrl_if.slave bus,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int LINES = 2**INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]         r_addr;
  logic [1:0]          r_beat;
  logic                r_err_pend;
  logic                r_drop;
  logic [LINES-1:0]    r_vbit;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [15:0]         r_data [LINES][4];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [1:0]            w_off;
  logic                  w_mis;
  logic                  w_hit;
  logic [15:0]           w_word;
  logic                  w_lookup_miss;
  logic                  w_ready;
  logic                  w_valid;
  logic                  w_err;
  logic [15:0]           w_instr;
  logic                  w_mem_rd;
  logic [15:0]           w_mem_addr;

  assign w_idx  = r_addr[2+INDEX_BITS:3];
  assign w_tag  = r_addr[15:3+INDEX_BITS];
  assign w_off  = r_addr[2:1];
  assign w_mis  = r_addr[0];
  assign w_hit  = r_vbit[w_idx] &
                  (r_tag[w_idx] == w_tag);
  assign w_word = r_data[w_idx][w_off];

  assign w_lookup_miss = (r_state == S_LOOKUP) &
                         ~w_mis & ~w_hit;

  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_valid    = 1'b0;
    w_err      = 1'b0;
    w_instr    = '0;
    w_mem_rd   = 1'b0;
    w_mem_addr = '0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.rd) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_mis | w_hit) begin
          w_ready = 1'b1;
          w_valid = ~bus.abort;
          w_err   = w_mis & ~bus.abort;
          w_instr = w_mis ? 16'h0000 : w_word;
          w_next  = bus.rd ? S_LOOKUP : S_IDLE;
        end else begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = {w_tag, w_idx, r_beat, 1'b0};
        if (bus.mem_rvalid && r_beat == 2'd3)
          w_next = S_RESPOND;
      end
      S_RESPOND: begin
        w_valid = ~r_drop & ~bus.abort;
        w_err   = w_valid & r_err_pend;
        w_instr = w_word;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ready is forced low while reset is held, even though state is IDLE
  assign bus.ready    = w_ready & rst;
  assign bus.valid    = w_valid;
  assign bus.err      = w_err;
  assign bus.instr    = w_instr;
  assign bus.mem_rd   = w_mem_rd;
  assign bus.mem_addr = w_mem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_beat     <= '0;
      r_err_pend <= 1'b0;
      r_drop     <= 1'b0;
      r_vbit     <= '0;
    end else begin
      r_state <= w_next;
      if (w_ready && bus.rd)
        r_addr <= bus.addr;
      // line is invalid for the whole fill so an error leaves it clear
      if (w_lookup_miss) begin
        r_beat          <= '0;
        r_err_pend      <= 1'b0;
        r_drop          <= bus.abort;
        r_vbit[w_idx]   <= 1'b0;
      end
      if (r_state == S_FILL) begin
        if (bus.abort) r_drop <= 1'b1;
        if (bus.mem_rvalid) begin
          r_beat <= r_beat + 2'd1;
          if (bus.mem_err) r_err_pend <= 1'b1;
          if (r_beat == 2'd3)
            r_vbit[w_idx] <= ~(r_err_pend | bus.mem_err);
        end
      end
      if (r_state == S_RESPOND)
        r_err_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL && bus.mem_rvalid) begin
      r_data[w_idx][r_beat] <= bus.mem_rdata;
      if (r_beat == 2'd3)
        r_tag[w_idx] <= w_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic        w_lookup_hit;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  assign w_lookup_hit = (r_state == S_LOOKUP) &
                        ~w_mis & w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_lookup_hit && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_lookup_miss && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl; memory word at address a reads as a|A000.
// Counter expectations follow ICACHE_STATS_EN.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        mem_on;
  logic [15:0] err_addr;
  int          total = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  icache_ctrl_if bus();

  icache_ctrl #(
    .INDEX_BITS(5),
    .TAG_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always_comb begin
    bus.mem_rvalid = bus.mem_rd & mem_on;
    bus.mem_rdata  = 16'hA000 | bus.mem_addr;
    bus.mem_err    = bus.mem_rd & mem_on &
                     (bus.mem_addr == err_addr);
  end

  function automatic logic [15:0] st(input int v);
`ifdef ICACHE_STATS_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // IDLE cycle presenting a new request
  task automatic issue(input logic [15:0] a);
    cyc();
    bus.rd   = 1'b1;
    bus.addr = a;
    smp();
    chk("idle_ready", {15'd0, bus.ready}, 16'd1);
  endtask

  // four fill beats; abort raised on beat ab (-1 for none)
  task automatic fill(input logic [15:0] base,
                      input int ab);
    for (int b = 0; b < 4; b++) begin
      cyc();
      bus.rd    = 1'b0;
      bus.abort = (b == ab);
      smp();
      chk("fill_rd", {15'd0, bus.mem_rd}, 16'd1);
      chk("fill_addr", bus.mem_addr,
          base + 16'(2 * b));
      chk("fill_vld", {15'd0, bus.valid}, 16'd0);
    end
  endtask

  initial begin
    bus.rd    = 1'b0;
    bus.addr  = '0;
    bus.abort = 1'b0;
    mem_on    = 1'b1;
    err_addr  = 16'hFFFF;

    repeat (2) smp();
    chk("rst_ready", {15'd0, bus.ready}, 16'd0);
    chk("rst_valid", {15'd0, bus.valid}, 16'd0);
    chk("rst_err", {15'd0, bus.err}, 16'd0);
    chk("rst_memrd", {15'd0, bus.mem_rd}, 16'd0);
    chk("rst_memaddr", bus.mem_addr, 16'h0000);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_hit", hit_cnt, 16'h0000);
    chk("rst_miss", miss_cnt, 16'h0000);
    cyc();
    rst = 1'b1;
    smp();
    chk("post_rst_ready", {15'd0, bus.ready}, 16'd1);

    // cold miss on 0040
    issue(16'h0040);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("miss_valid", {15'd0, bus.valid}, 16'd0);
    chk("miss_ready", {15'd0, bus.ready}, 16'd0);
    chk("miss_memrd", {15'd0, bus.mem_rd}, 16'd0);
    fill(16'h0040, -1);
    cyc();
    bus.abort = 1'b0;
    smp();
    chk("resp_valid", {15'd0, bus.valid}, 16'd1);
    chk("resp_instr", bus.instr, 16'hA040);
    chk("resp_err", {15'd0, bus.err}, 16'd0);
    chk("resp_ready", {15'd0, bus.ready}, 16'd0);
    chk("miss_cnt1", miss_cnt, st(1));

    // back-to-back hits
    issue(16'h0042);
    cyc();
    bus.addr = 16'h0044;
    smp();
    chk("hit1_valid", {15'd0, bus.valid}, 16'd1);
    chk("hit1_instr", bus.instr, 16'hA042);
    chk("hit1_ready", {15'd0, bus.ready}, 16'd1);
    chk("hit1_memrd", {15'd0, bus.mem_rd}, 16'd0);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("hit2_valid", {15'd0, bus.valid}, 16'd1);
    chk("hit2_instr", bus.instr, 16'hA044);
    chk("hit2_ready", {15'd0, bus.ready}, 16'd1);
    chk("hit2_memrd", {15'd0, bus.mem_rd}, 16'd0);
    cyc();
    smp();
    chk("hit_cnt2", hit_cnt, st(2));
    chk("idle_valid", {15'd0, bus.valid}, 16'd0);

    // conflicting tag replaces the line, then back again
    issue(16'h0440);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("conf_miss", {15'd0, bus.ready}, 16'd0);
    fill(16'h0440, -1);
    cyc();
    bus.abort = 1'b0;
    smp();
    chk("conf_instr", bus.instr, 16'hA440);
    issue(16'h0040);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("back_miss", {15'd0, bus.ready}, 16'd0);
    fill(16'h0040, -1);
    cyc();
    bus.abort = 1'b0;
    smp();
    chk("back_valid", {15'd0, bus.valid}, 16'd1);
    chk("back_instr", bus.instr, 16'hA040);
    chk("miss_cnt3", miss_cnt, st(3));

    // misaligned
    issue(16'h0081);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("mis_valid", {15'd0, bus.valid}, 16'd1);
    chk("mis_err", {15'd0, bus.err}, 16'd1);
    chk("mis_instr", bus.instr, 16'h0000);
    chk("mis_memrd", {15'd0, bus.mem_rd}, 16'd0);
    chk("mis_ready", {15'd0, bus.ready}, 16'd1);
    cyc();
    smp();
    chk("mis_hitcnt", hit_cnt, st(2));
    chk("mis_misscnt", miss_cnt, st(3));

    // abort during fill beat 1
    issue(16'h0100);
    cyc();
    bus.rd = 1'b0;
    smp();
    fill(16'h0100, 1);
    cyc();
    bus.abort = 1'b0;
    smp();
    chk("abort_resp_valid", {15'd0, bus.valid}, 16'd0);
    issue(16'h0100);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("abort_rehit_valid", {15'd0, bus.valid}, 16'd1);
    chk("abort_rehit_instr", bus.instr, 16'hA100);
    chk("abort_rehit_memrd", {15'd0, bus.mem_rd}, 16'd0);

    // aborted hit with a same-cycle new request
    issue(16'h0100);
    cyc();
    bus.rd    = 1'b1;
    bus.addr  = 16'h0042;
    bus.abort = 1'b1;
    smp();
    chk("abhit_valid", {15'd0, bus.valid}, 16'd0);
    chk("abhit_ready", {15'd0, bus.ready}, 16'd1);
    cyc();
    bus.rd    = 1'b0;
    bus.abort = 1'b0;
    smp();
    chk("newreq_valid", {15'd0, bus.valid}, 16'd1);
    chk("newreq_instr", bus.instr, 16'hA042);
    cyc();
    smp();
    chk("hit_cnt5", hit_cnt, st(5));
    chk("miss_cnt4", miss_cnt, st(4));

    // memory error on beat 2
    err_addr = 16'h0204;
    issue(16'h0200);
    cyc();
    bus.rd = 1'b0;
    smp();
    fill(16'h0200, -1);
    cyc();
    bus.abort = 1'b0;
    smp();
    chk("merr_valid", {15'd0, bus.valid}, 16'd1);
    chk("merr_err", {15'd0, bus.err}, 16'd1);
    err_addr = 16'hFFFF;
    issue(16'h0200);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("merr_remiss_vld", {15'd0, bus.valid}, 16'd0);
    chk("merr_remiss_rdy", {15'd0, bus.ready}, 16'd0);

    // reset in the middle of the refill
    cyc();
    smp();
    chk("rfill_addr0", bus.mem_addr, 16'h0200);
    cyc();
    rst = 1'b0;
    smp();
    chk("midrst_ready", {15'd0, bus.ready}, 16'd0);
    chk("midrst_valid", {15'd0, bus.valid}, 16'd0);
    chk("midrst_memrd", {15'd0, bus.mem_rd}, 16'd0);
    chk("midrst_miss", miss_cnt, 16'h0000);
    cyc();
    rst = 1'b1;
    smp();
    chk("rerst_ready", {15'd0, bus.ready}, 16'd1);
    issue(16'h0200);
    cyc();
    bus.rd = 1'b0;
    smp();
    chk("after_rst_miss", {15'd0, bus.ready}, 16'd0);
    chk("after_rst_vld", {15'd0, bus.valid}, 16'd0);
    fill(16'h0200, -1);
    cyc();
    bus.abort = 1'b0;
    smp();
    chk("final_valid", {15'd0, bus.valid}, 16'd1);
    chk("final_err", {15'd0, bus.err}, 16'd0);
    chk("final_instr", bus.instr, 16'hA200);
    chk("final_miss", miss_cnt, st(1));

    $display("%0d/%0d checks passed",
             total - fails, total);
    $finish;
  end

endmodule
